// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO word packer.
package fifo_pkg;

  typedef enum logic {PK_FILL, PK_HOLD} pack_state_e;

  // Lane index width; kept at least one bit so a counter always exists.
  function automatic int unsigned lane_idx_w(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle counter for partial beats: clear, count while enabled, flag the last idle cycle.
module pack_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (clr_i) begin
      idle_d = '0;
    end else if (en_i && !expire_o && (TIMEOUT_CYC != 0)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expire_o = 1'b0;
    end else begin : g_on
      assign expire_o = en_i && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/fifo_word_packer.sv
// Pops narrow words from an FWFT FIFO and packs RATIO of them into one valid/ready beat.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RATIO       = 4,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  input  logic [DATA_W-1:0]        fifo_rd_data,
  output logic                     fifo_rd_en,
  input  logic                     flush_req,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W*RATIO-1:0]  m_data,
  output logic [RATIO-1:0]         m_keep
);

  localparam int unsigned CNT_W  = lane_idx_w(RATIO);
  localparam int unsigned BEAT_W = DATA_W * RATIO;

  pack_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BEAT_W-1:0]  data_q, data_d;
  logic [RATIO-1:0]   keep_q, keep_d;
  logic               pop;
  logic               last_lane;
  logic               idle_en;
  logic               idle_expire;

  assign pop        = rst_n && !fifo_empty &&
                      ((state_q == PK_FILL) || ((state_q == PK_HOLD) && m_ready));
  assign fifo_rd_en = pop;
  assign last_lane  = (cnt_q == CNT_W'(RATIO - 1));
  assign idle_en    = (state_q == PK_FILL) && (cnt_q != '0) && !pop;

  pack_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!idle_en),
    .en_i     (idle_en),
    .expire_o (idle_expire)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    case (state_q)
      PK_FILL: begin
        if (pop) begin
          for (int unsigned i = 0; i < RATIO; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              data_d[i*DATA_W +: DATA_W] = fifo_rd_data;
              keep_d[i]                  = 1'b1;
            end
          end
          if (last_lane || flush_req) begin
            state_d = PK_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if ((flush_req && (cnt_q != '0)) || idle_expire) begin
          state_d = PK_HOLD;
          cnt_d   = '0;
        end
      end
      PK_HOLD: begin
        // Handshake frees the beat; a word popped in the same cycle starts the next one.
        if (m_ready) begin
          state_d = PK_FILL;
          data_d  = '0;
          keep_d  = '0;
          cnt_d   = '0;
          if (pop) begin
            data_d[DATA_W-1:0] = fifo_rd_data;
            keep_d[0]          = 1'b1;
            cnt_d              = CNT_W'(1);
          end
        end
      end
      default: state_d = PK_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PK_FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  assign m_valid = (state_q == PK_HOLD);
  assign m_data  = data_q;
  assign m_keep  = keep_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a FIFO model feeds the DUT, expected beats are queued.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        fifo_empty, fifo_rd_en, flush_req, m_valid, m_ready;
  logic [15:0] fifo_rd_data;
  logic [63:0] m_data;
  logic [3:0]  m_keep;

  logic        fifo2_empty, fifo2_rd_en, flush2, m_valid2, m_ready2;
  logic [15:0] fifo2_rd_data;
  logic [63:0] m_data2;
  logic [3:0]  m_keep2;

  logic [15:0] fifo_q[$];
  logic [15:0] fifo2_q[$];
  logic [63:0] exp_data_q[$];
  logic [3:0]  exp_keep_q[$];
  int          hs_log[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  logic popped, popped2;
  logic v2_seen = 1'b0;

  always #5 clk = ~clk;

  fifo_word_packer #(.DATA_W(16), .RATIO(4), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .flush_req(flush_req), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep)
  );

  fifo_word_packer #(.DATA_W(16), .RATIO(4), .TIMEOUT_CYC(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo2_empty), .fifo_rd_data(fifo2_rd_data),
    .fifo_rd_en(fifo2_rd_en), .flush_req(flush2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .m_keep(m_keep2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_beat(input logic [63:0] d, input logic [3:0] k);
    exp_data_q.push_back(d);
    exp_keep_q.push_back(k);
  endtask

  // One clock: present FIFO heads, score any handshake, advance, retire popped words.
  task automatic cycle();
    fifo_empty    = (fifo_q.size() == 0);
    fifo_rd_data  = fifo_empty ? 16'h0 : fifo_q[0];
    fifo2_empty   = (fifo2_q.size() == 0);
    fifo2_rd_data = fifo2_empty ? 16'h0 : fifo2_q[0];
    #1;
    popped  = fifo_rd_en;
    popped2 = fifo2_rd_en;
    check_eq("pop_on_empty", {63'd0, fifo_rd_en & fifo_empty}, 64'd0);
    if (m_valid && m_ready) begin
      hs_log.push_back(cyc);
      check_eq("beat_expected", {63'd0, exp_data_q.size() != 0}, 64'd1);
      if (exp_data_q.size() != 0) begin
        check_eq("beat_data", m_data, exp_data_q.pop_front());
        check_eq("beat_keep", {60'd0, m_keep}, {60'd0, exp_keep_q.pop_front()});
      end
    end
    v2_seen = v2_seen | m_valid2;
    @(posedge clk);
    cyc++;
    if (popped) begin
      void'(fifo_q.pop_front());
      last_pop_cyc = cyc;
    end
    if (popped2) void'(fifo2_q.pop_front());
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_data_q.size() != 0; i++) cycle();
    check_eq("drain_done", exp_data_q.size(), 64'd0);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !m_valid; i++) cycle();
    check_eq("valid_seen", {63'd0, m_valid}, 64'd1);
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 1; i <= n; i++) fifo_q.push_back(base + 16'(i));
  endtask

  task automatic do_reset();
    fifo_q.delete();
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", {63'd0, m_valid}, 64'd0);
    check_eq("rst_keep", {60'd0, m_keep}, 64'd0);
    check_eq("rst_data", m_data, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    fifo_empty = 1'b1; fifo_rd_data = '0; flush_req = 1'b0; m_ready = 1'b0;
    fifo2_empty = 1'b1; fifo2_rd_data = '0; flush2 = 1'b0; m_ready2 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    fifo_empty = 1'b0;
    fifo_rd_data = 16'h1234;
    #1;
    check_eq("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check_eq("rst_valid", {63'd0, m_valid}, 64'd0);
    check_eq("rst_keep", {60'd0, m_keep}, 64'd0);
    check_eq("rst_data", m_data, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two full beats back to back
    m_ready = 1'b1;
    push_words(16'h0000, 8);
    expect_beat(64'h0004_0003_0002_0001, 4'hF);
    expect_beat(64'h0008_0007_0006_0005, 4'hF);
    hs_log.delete();
    drain(20);
    check_eq("beat_gap", (hs_log.size() == 2) ? 64'(hs_log[1] - hs_log[0]) : 64'd0, 64'd4);

    // Explicit flush of a two-word partial beat
    fifo_q.push_back(16'hAAAA);
    fifo_q.push_back(16'hBBBB);
    cycle(); cycle(); cycle();
    check_eq("flush_pre_valid", {63'd0, m_valid}, 64'd0);
    check_eq("partial_keep", {60'd0, m_keep}, 64'h3);
    expect_beat(64'h0000_0000_BBBB_AAAA, 4'h3);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    check_eq("flush_lat", {63'd0, m_valid}, 64'd1);
    drain(5);

    // Idle timeout auto-emit
    push_words(16'h0C00, 3);
    expect_beat(64'h0000_0C03_0C02_0C01, 4'h7);
    cycle(); cycle(); cycle();
    for (int i = 0; i < 40 && !m_valid; i++) cycle();
    check_eq("timeout_lat", 64'(cyc - last_pop_cyc), 64'd32);
    check_eq("timeout_keep", {60'd0, m_keep}, 64'h7);
    drain(5);

    // Timeout disabled: partial beat stays put until flushed
    for (int i = 1; i <= 3; i++) fifo2_q.push_back(16'h0D00 + 16'(i));
    v2_seen = 1'b0;
    for (int i = 0; i < 45; i++) cycle();
    check_eq("nt_no_beat", {63'd0, v2_seen}, 64'd0);
    check_eq("nt_keep", {60'd0, m_keep2}, 64'h7);
    flush2 = 1'b1;
    cycle();
    flush2 = 1'b0;
    check_eq("nt_flush_valid", {63'd0, m_valid2}, 64'd1);
    check_eq("nt_flush_data", m_data2, 64'h0000_0D03_0D02_0D01);
    cycle();
    check_eq("nt_after_hs", {63'd0, m_valid2}, 64'd0);

    // Backpressure with a full beat held and more words waiting
    m_ready = 1'b0;
    push_words(16'h4400, 5);
    expect_beat(64'h4404_4403_4402_4401, 4'hF);
    expect_beat(64'h0000_0000_0000_4405, 4'h1);
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("hold_no_pop", {63'd0, popped}, 64'd0);
      check_eq("hold_data", m_data, 64'h4404_4403_4402_4401);
    end
    m_ready = 1'b1;
    cycle();
    check_eq("hs_pop", {63'd0, popped}, 64'd1);
    check_eq("hs_lane0_keep", {60'd0, m_keep}, 64'h1);
    check_eq("hs_lane0_data", m_data, 64'h0000_0000_0000_4405);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    drain(5);

    // Flush with nothing packed, and flush while holding
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    check_eq("flush_empty_valid", {63'd0, m_valid}, 64'd0);
    check_eq("flush_empty_keep", {60'd0, m_keep}, 64'd0);
    cycle(); cycle();
    m_ready = 1'b0;
    push_words(16'h5500, 4);
    expect_beat(64'h5504_5503_5502_5501, 4'hF);
    wait_valid(10);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    check_eq("flush_hold_valid", {63'd0, m_valid}, 64'd1);
    check_eq("flush_hold_keep", {60'd0, m_keep}, 64'hF);
    m_ready = 1'b1;
    drain(5);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("no_extra_beat", {63'd0, m_valid}, 64'd0);
    end

    // Reset with two lanes packed, then mid-hold
    push_words(16'h6600, 2);
    cycle(); cycle();
    check_eq("pre_rst_keep", {60'd0, m_keep}, 64'h3);
    do_reset();
    push_words(16'h6610, 4);
    expect_beat(64'h6614_6613_6612_6611, 4'hF);
    drain(10);
    m_ready = 1'b0;
    push_words(16'h6620, 5);
    wait_valid(10);
    do_reset();
    push_words(16'h6640, 4);
    expect_beat(64'h6644_6643_6642_6641, 4'hF);
    m_ready = 1'b1;
    drain(10);

    check_eq("sb_empty", exp_data_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
